fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Downstream consumer of the byte FIFO: pops one entry at a time through the FIFO read port.
//   Serializes each entry onto an 8N1 UART line, LSB first (optional parity bit, see CONFIGURATION).
//   Sits between the FIFO read side and the board TX pin; keeps draining while the FIFO is non-empty and tx_en is high.
// PARAMETERS
//   CLOCK_FREQ  125_000_000  system clock frequency, Hz
//   BAUD_RATE   115_200      line rate, bit/s; CPB = CLOCK_FREQ/BAUD_RATE (truncated); CPB >= 2 is required
//   DATA_WIDTH  8            data bits per frame; must equal the FIFO data_width
// PORTS
//   clk         in   1           system clock, all state on rising edge
//   rst         in   1           asynchronous, active-low reset
//   tx_en       in   1           1 = start new frames; 0 = finish the current frame, then hold in IDLE
//   fifo_empty  in   1           FIFO empty flag
//   fifo_dout   in   DATA_WIDTH  FIFO read data, valid the cycle after a fifo_rd_en pulse
//   fifo_rd_en  out  1           one-cycle pop request to the FIFO
//   serial_out  out  1           UART TX line, idle high
//   busy        out  1           high from FETCH through the end of STOP
//   frame_done  out  1           one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, serial_out=1, fifo_rd_en=0, busy=0, frame_done=0.
//     Also clears the shift register, baud counter and bit counter.
//     Reset mid-frame: the line returns high immediately; the popped byte is lost.
//   FSM states: IDLE, FETCH, LOAD, START, DATA, [PARITY], STOP.
//   IDLE: serial_out=1. If tx_en && !fifo_empty, go to FETCH next cycle.
//   FETCH: 1 cycle, fifo_rd_en=1. Re-checks fifo_empty in this cycle; if empty, returns to IDLE with fifo_rd_en=0.
//   LOAD: 1 cycle, fifo_rd_en=0. Captures fifo_dout into shreg (FIFO has 1-cycle registered read latency).
//   START: serial_out=0 for exactly CPB cycles.
//   DATA: DATA_WIDTH bits, each held CPB cycles.
//     serial_out=shreg[0]; shreg shifts right at each bit boundary; bit counter runs 0..DATA_WIDTH-1.
//   STOP: serial_out=1 for CPB cycles; frame_done=1 on the final cycle.
//     Then go to FETCH if tx_en && !fifo_empty, else IDLE.
//   Baud counter: width `log2(CPB)+1; counts 0..CPB-1; wraps to 0 at each bit boundary and on every state entry.
//   Frame length: exactly (DATA_WIDTH+2)*CPB cycles of line time (+CPB if parity).
//   Back-to-back frames: the 2-cycle FETCH/LOAD gap is idle-high. The stop bit therefore lasts CPB+2 cycles.
//   fifo_rd_en is never high while fifo_empty=1 in the same cycle.
//   Exactly one pop per frame; no pop in any other state.
//   tx_en dropping mid-frame does not truncate the frame.
//   tx_en is sampled only in IDLE and on the last STOP cycle.
//   serial_out is driven from a register (glitch-free); every output is registered except fifo_rd_en.
//     fifo_rd_en is decoded from state==FETCH && !fifo_empty.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: a PARITY state of CPB cycles is inserted between DATA and STOP.
//     Parity is even: serial_out = ^byte, computed in LOAD.
//   UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; DATA goes directly to STOP (8N1).
// TESTING (sim: CLOCK_FREQ=1000, BAUD_RATE=100 -> CPB=10)
//   1 Reset: hold rst=0 for 3 cycles with an empty FIFO
//     -> serial_out=1, fifo_rd_en=0, busy=0, frame_done=0 throughout.
//   2 Single byte: FIFO={8'hA5}, tx_en=1
//     -> one rd_en pulse; line = 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles.
//     -> frame_done pulses once; fifo_empty=1 and busy=0 afterwards.
//   3 Back-to-back: FIFO={8'h00,8'hFF,8'h3C}
//     -> 3 frames decoded by a bench UART RX model; exactly 3 rd_en pulses; 2-cycle idle gap between frames.
//   4 tx_en=0 asserted in the middle of frame 1 of 2 -> frame 1 completes intact.
//     -> Line stays idle and FIFO keeps 1 entry; tx_en=1 then sends the second byte.
//   5 Reset mid-frame: rst=0 during data bit 3 -> serial_out=1 the same cycle.
//     -> After release, the next FIFO entry is sent complete.
//   6 UART_TX_PARITY_EN: 8'h07 -> parity bit=1; 8'h03 -> parity bit=0; frame = 110 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a byte FIFO onto a UART TX line. Each entry is popped through the
//   FIFO read port, captured one cycle later (registered FIFO read), and sent
//   as a frame: start bit, DATA_WIDTH data bits LSB first, optional even
//   parity bit, and one stop bit. Every bit is held CPB = CLOCK_FREQ/BAUD_RATE
//   clock cycles. New frames start only while tx_en is high.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
//   between the last data bit and the stop bit. Without it the frame is 8N1.
//
// Ports
//   clk         in   system clock, all state on the rising edge
//   rst         in   asynchronous active-low reset
//   tx_en       in   1 = start new frames; 0 = finish current frame, then idle
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  one-cycle pop request (combinational from state)
//   serial_out  out  UART TX line, idle high, registered
//   busy        out  high from FETCH through the end of STOP, registered
//   frame_done  out  one-cycle pulse on the last stop-bit cycle, registered
module fifo_uart_tx #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  // Line states are encoded at and above S_START so "driving the line"
  // is a single magnitude compare.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         baud_reg, baud_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
  logic                  serial_out_reg, serial_out_next;
  logic                  busy_reg, busy_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif

  assign bit_end = (baud_reg == CPB_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (tx_en && !fifo_empty) state_next = S_FETCH;
      // The FIFO can empty between the IDLE decision and the pop.
      S_FETCH:  state_next = fifo_empty ? S_IDLE : S_LOAD;
      S_LOAD:   state_next = S_START;
      S_START:  if (bit_end) state_next = S_DATA;
      S_DATA:
        if (bit_end && (bit_reg == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_next = S_STOP;
`endif
      S_STOP:
        if (bit_end) state_next = (tx_en && !fifo_empty) ? S_FETCH : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath next values: baud/bit counters and shift register
  always_comb begin
    // Counter restarts on every bit boundary and every state change.
    baud_next = '0;
    if ((state_reg >= S_START) && (state_next == state_reg) && !bit_end)
      baud_next = baud_reg + 1'b1;

    bit_next = bit_reg;
    if (state_reg != S_DATA) bit_next = '0;
    else if (bit_end)        bit_next = bit_reg + 1'b1;

    shreg_next = shreg_reg;
    if (state_reg == S_LOAD)                  shreg_next = fifo_dout;
    else if ((state_reg == S_DATA) && bit_end) shreg_next = shreg_reg >> 1;

`ifdef UART_TX_PARITY_EN
    parity_next = (state_reg == S_LOAD) ? ^fifo_dout : parity_reg;
`endif
  end

  // Output logic. Registered outputs are computed from the next state so the
  // registered value lines up with the state it belongs to.
  always_comb begin
    fifo_rd_en      = (state_reg == S_FETCH) && !fifo_empty;
    busy_next       = (state_next != S_IDLE);
    frame_done_next = (state_next == S_STOP) && (baud_next == CPB_LAST);
    case (state_next)
      S_START:  serial_out_next = 1'b0;
      S_DATA:   serial_out_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_out_next = parity_reg;
`endif
      default:  serial_out_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_reg       <= '0;
      bit_reg        <= '0;
      shreg_reg      <= '0;
      serial_out_reg <= 1'b1;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      baud_reg       <= baud_next;
      bit_reg        <= bit_next;
      shreg_reg      <= shreg_next;
      serial_out_reg <= serial_out_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg     <= parity_next;
`endif
    end
  end

  assign serial_out = serial_out_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLOCK_FREQ=1000, BAUD_RATE=100
//   (10 clocks per bit). A small FIFO model with one-cycle registered read
//   feeds the DUT; a receive task samples the line every cycle and checks
//   that each bit is stable for its full bit time.
module tb_fifo_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int START_TIMEOUT = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       serial_out;
  logic       busy;
  logic       frame_done;

  logic [7:0] mem_q[$];
  logic [7:0] stage_q[$];
  int         rd_pulses = 0;
  int         bad_pops = 0;

  int n_vec = 0;
  int n_err = 0;

  fifo_uart_tx #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .serial_out(serial_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: writes staged by the tests land on the next edge, reads
  // return data one cycle after fifo_rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (fifo_empty) bad_pops <= bad_pops + 1;
      if (mem_q.size() != 0) fifo_dout <= mem_q.pop_front();
    end
    while (stage_q.size() != 0) mem_q.push_back(stage_q.pop_front());
    fifo_empty <= (mem_q.size() == 0);
  end

  // Receive one frame: wait for the start bit, then sample NB*CPB cycles.
  task automatic rx_frame(output logic [NB-1:0] bits, output logic stable,
                          output int done_cnt, output logic done_last,
                          output logic busy_all, output int idle_cnt,
                          output logic found);
    logic s;
    bits = '0; stable = 1'b1; done_cnt = 0; done_last = 1'b0;
    busy_all = 1'b1; idle_cnt = 0; found = 1'b0;
    for (int w = 0; w < START_TIMEOUT && !found; w++) begin
      @(negedge clk);
      if (serial_out === 1'b0) found = 1'b1;
      else idle_cnt++;
    end
    if (found) begin
      for (int i = 0; i < NB * CPB; i++) begin
        if (i > 0) @(negedge clk);
        s = serial_out;
        if (i % CPB == 0) bits[i / CPB] = s;
        else if (s !== bits[i / CPB]) stable = 1'b0;
        if (frame_done === 1'b1) begin
          done_cnt++;
          if (i == NB * CPB - 1) done_last = 1'b1;
        end
        if (busy !== 1'b1) busy_all = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1; tx_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    obs = {serial_out, fifo_rd_en, busy, frame_done};
    n_vec++;
    if (obs !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_async: {line,rd_en,busy,done} got %b expected 1000", obs);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = {serial_out, fifo_rd_en, busy, frame_done};
      n_vec++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got %b expected 1000", c, obs);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    $display("reset: outputs {line,rd_en,busy,done}=%b", {serial_out, fifo_rd_en, busy, frame_done});
  endtask

  task automatic test_single_byte();
    logic [NB-1:0] bits, exp_bits;
    logic stable, done_last, busy_all, found;
    int done_cnt, idle_cnt, p0, b0;
`ifdef UART_TX_PARITY_EN
    exp_bits = 11'b10101001010;
`else
    exp_bits = 10'b1101001010;
`endif
    p0 = rd_pulses; b0 = bad_pops;
    tx_en = 1'b1;
    stage_q.push_back(8'hA5);
    rx_frame(bits, stable, done_cnt, done_last, busy_all, idle_cnt, found);
    $display("single: line bits=%b found=%0d", bits, found);
    n_vec++;
    if (found !== 1'b1) begin n_err++; $display("FAIL single_start: found=%0d expected 1", found); end
    n_vec++;
    if (bits !== exp_bits) begin n_err++; $display("FAIL single_bits: got %b expected %b", bits, exp_bits); end
    n_vec++;
    if (stable !== 1'b1) begin n_err++; $display("FAIL single_bit_time: stable=%0d expected 1", stable); end
    n_vec++;
    if (done_cnt != 1 || done_last !== 1'b1) begin
      n_err++; $display("FAIL single_frame_done: count=%0d at_last=%0d expected 1/1", done_cnt, done_last);
    end
    n_vec++;
    if (busy_all !== 1'b1) begin n_err++; $display("FAIL single_busy: busy_all=%0d expected 1", busy_all); end
    repeat (3) @(negedge clk);
    n_vec++;
    if (rd_pulses - p0 != 1) begin n_err++; $display("FAIL single_pops: got %0d expected 1", rd_pulses - p0); end
    n_vec++;
    if ({fifo_empty, busy, serial_out} !== 3'b101) begin
      n_err++; $display("FAIL single_after: {empty,busy,line} got %b expected 101", {fifo_empty, busy, serial_out});
    end
    n_vec++;
    if (bad_pops != b0) begin n_err++; $display("FAIL single_pop_empty: got %0d expected %0d", bad_pops, b0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    logic [NB-1:0] bits;
    logic stable, done_last, busy_all, found;
    int done_cnt, idle_cnt, p0;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    p0 = rd_pulses;
    tx_en = 1'b1;
    for (int k = 0; k < 3; k++) stage_q.push_back(exp_b[k]);
    for (int k = 0; k < 3; k++) begin
      rx_frame(bits, stable, done_cnt, done_last, busy_all, idle_cnt, found);
      $display("b2b frame %0d: data=%02h idle_before=%0d", k, bits[8:1], idle_cnt);
      n_vec++;
      if (bits[8:1] !== exp_b[k] || found !== 1'b1) begin
        n_err++; $display("FAIL b2b_data %0d: got %02h expected %02h", k, bits[8:1], exp_b[k]);
      end
      n_vec++;
      if ({bits[NB-1], bits[0], stable} !== 3'b101) begin
        n_err++; $display("FAIL b2b_framing %0d: {stop,start,stable} got %b expected 101", k, {bits[NB-1], bits[0], stable});
      end
      n_vec++;
      if (done_cnt != 1 || done_last !== 1'b1) begin
        n_err++; $display("FAIL b2b_frame_done %0d: count=%0d at_last=%0d expected 1/1", k, done_cnt, done_last);
      end
      if (k > 0) begin
        n_vec++;
        if (idle_cnt != 2) begin n_err++; $display("FAIL b2b_gap %0d: got %0d expected 2", k, idle_cnt); end
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (rd_pulses - p0 != 3) begin n_err++; $display("FAIL b2b_pops: got %0d expected 3", rd_pulses - p0); end
  endtask

  task automatic test_tx_en_drop();
    logic [NB-1:0] bits;
    logic stable, done_last, busy_all, found;
    int done_cnt, idle_cnt, p0, idle_bad;
    p0 = rd_pulses;
    tx_en = 1'b1;
    stage_q.push_back(8'h5A);
    stage_q.push_back(8'h81);
    fork
      rx_frame(bits, stable, done_cnt, done_last, busy_all, idle_cnt, found);
      begin
        repeat (40) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    $display("tx_en drop frame 1: data=%02h", bits[8:1]);
    n_vec++;
    if (bits[8:1] !== 8'h5A || {bits[NB-1], bits[0], stable, found} !== 4'b1011) begin
      n_err++; $display("FAIL drop_frame1: data %02h {stop,start,stable,found}=%b expected 5A/1011",
                        bits[8:1], {bits[NB-1], bits[0], stable, found});
    end
    n_vec++;
    if (done_cnt != 1 || done_last !== 1'b1) begin
      n_err++; $display("FAIL drop_frame_done: count=%0d at_last=%0d expected 1/1", done_cnt, done_last);
    end
    idle_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) idle_bad++;
    end
    n_vec++;
    if (idle_bad != 0) begin n_err++; $display("FAIL drop_hold_idle: non-idle cycles %0d expected 0", idle_bad); end
    n_vec++;
    if (fifo_empty !== 1'b0 || rd_pulses - p0 != 1) begin
      n_err++; $display("FAIL drop_fifo_kept: empty=%0d pops=%0d expected 0/1", fifo_empty, rd_pulses - p0);
    end
    tx_en = 1'b1;
    rx_frame(bits, stable, done_cnt, done_last, busy_all, idle_cnt, found);
    $display("tx_en drop frame 2: data=%02h", bits[8:1]);
    n_vec++;
    if (bits[8:1] !== 8'h81 || {bits[NB-1], bits[0], stable, found} !== 4'b1011) begin
      n_err++; $display("FAIL drop_frame2: data %02h {stop,start,stable,found}=%b expected 81/1011",
                        bits[8:1], {bits[NB-1], bits[0], stable, found});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (rd_pulses - p0 != 2) begin n_err++; $display("FAIL drop_pops: got %0d expected 2", rd_pulses - p0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [NB-1:0] bits;
    logic stable, done_last, busy_all, found;
    int done_cnt, idle_cnt, p0, b0;
    p0 = rd_pulses; b0 = bad_pops;
    tx_en = 1'b1;
    stage_q.push_back(8'hC3);
    stage_q.push_back(8'h96);
    found = 1'b0;
    for (int w = 0; w < START_TIMEOUT && !found; w++) begin
      @(negedge clk);
      if (serial_out === 1'b0) found = 1'b1;
    end
    repeat (44) @(negedge clk);   // middle of data bit 3 (bit value 0)
    n_vec++;
    if (serial_out !== 1'b0 || found !== 1'b1) begin
      n_err++; $display("FAIL midrst_before: line=%b found=%0d expected 0/1", serial_out, found);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({serial_out, busy, frame_done, fifo_rd_en} !== 4'b1000) begin
      n_err++; $display("FAIL midrst_async: {line,busy,done,rd_en} got %b expected 1000",
                        {serial_out, busy, frame_done, fifo_rd_en});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rx_frame(bits, stable, done_cnt, done_last, busy_all, idle_cnt, found);
    $display("reset mid-frame: next data=%02h", bits[8:1]);
    n_vec++;
    if (bits[8:1] !== 8'h96 || {bits[NB-1], bits[0], stable, found} !== 4'b1011) begin
      n_err++; $display("FAIL midrst_next: data %02h {stop,start,stable,found}=%b expected 96/1011",
                        bits[8:1], {bits[NB-1], bits[0], stable, found});
    end
    n_vec++;
    if (done_cnt != 1 || done_last !== 1'b1) begin
      n_err++; $display("FAIL midrst_frame_done: count=%0d at_last=%0d expected 1/1", done_cnt, done_last);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (rd_pulses - p0 != 2 || fifo_empty !== 1'b1 || bad_pops != b0) begin
      n_err++; $display("FAIL midrst_pops: pops=%0d empty=%0d bad=%0d expected 2/1/%0d",
                        rd_pulses - p0, fifo_empty, bad_pops, b0);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] bits, exp_bits[2];
    logic stable, done_last, busy_all, found;
    int done_cnt, idle_cnt;
    exp_bits[0] = 11'b11000001110;   // 8'h07, parity 1
    exp_bits[1] = 11'b10000000110;   // 8'h03, parity 0
    tx_en = 1'b1;
    stage_q.push_back(8'h07);
    stage_q.push_back(8'h03);
    for (int k = 0; k < 2; k++) begin
      rx_frame(bits, stable, done_cnt, done_last, busy_all, idle_cnt, found);
      $display("parity frame %0d: bits=%b", k, bits);
      n_vec++;
      if (bits !== exp_bits[k] || found !== 1'b1) begin
        n_err++; $display("FAIL parity_bits %0d: got %b expected %b", k, bits, exp_bits[k]);
      end
      n_vec++;
      if (stable !== 1'b1 || done_cnt != 1 || done_last !== 1'b1) begin
        n_err++; $display("FAIL parity_len %0d: stable=%0d done=%0d at_last=%0d expected 1/1/1",
                          k, stable, done_cnt, done_last);
      end
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached limit 200000 before completion", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
